// File: rtl/fifo_rr_burst_arbiter.sv
// ---------------------------------------------------------------------------
// fifo_rr_burst_arbiter
//
// Drains N first-word-fall-through source FIFOs onto one shared valid/ready
// sink. One source is granted at a time for a burst of up to BURST words.
// Sources are served round-robin, and each word is tagged with its channel.
//
// Optional feature macro: FIFO_ARB_HALF_PRIO_EN
//   When defined, channels whose half flag is set win arbitration over the
//   other non-empty channels. Round-robin order is kept inside that group.
//   When undefined, src_half is ignored. The port remains in the interface.
//
// Ports
//   clk        in   1        rising-edge clock
//   rest       in   1        asynchronous reset, active low
//   flush      in   1        synchronous abort back to the reset state
//   src_empty  in   N        source FIFO empty flags
//   src_half   in   N        source FIFO half flags
//   src_data   in   N*WIDTH  source read data, channel i at [i*WIDTH +: WIDTH]
//   src_read   out  N        read strobes to the source FIFOs
//   out_valid  out  1        sink word valid
//   out_ready  in   1        sink accepts the word
//   out_data   out  WIDTH    sink data
//   out_chan   out  CW       channel index of out_data
//   out_last   out  1        final word of a full-length burst
//   abort      out  1        one-cycle pulse: a burst ended early on an empty source
//   busy       out  1        high while a burst is in progress
// ---------------------------------------------------------------------------
module fifo_rr_burst_arbiter #(
    parameter int N     = 4,
    parameter int WIDTH = 32,
    parameter int BURST = 8,
    localparam int CW   = ($clog2(N) < 1) ? 1 : $clog2(N)
) (
    input  logic               clk,
    input  logic               rest,
    input  logic               flush,
    input  logic [N-1:0]       src_empty,
    input  logic [N-1:0]       src_half,
    input  logic [N*WIDTH-1:0] src_data,
    output logic [N-1:0]       src_read,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic [CW-1:0]      out_chan,
    output logic               out_last,
    output logic               abort,
    output logic               busy
);

    localparam int BCW = $clog2(BURST) + 1;

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] BURST_ST = 1'b1;

    logic [0:0]     state_q,   state_d;
    logic [BCW-1:0] beatCnt_q, beatCnt_d;
    logic [CW-1:0]  grant_q,   grant_d;
    logic [CW-1:0]  rrLast_q,  rrLast_d;
    logic           abort_q,   abort_d;

    logic [WIDTH-1:0] srcWord [N];
    logic [N-1:0]     elig;
    logic             pickFound;
    logic [CW-1:0]    pickIdx;
    logic             move;

    for (genvar g = 0; g < N; g++) begin : gSplit
        assign srcWord[g] = src_data[g*WIDTH +: WIDTH];
    end

`ifdef FIFO_ARB_HALF_PRIO_EN
    // Channels that are at least half full take precedence when any exist.
    logic [N-1:0] halfSet;
    assign halfSet = ~src_empty & src_half;
    assign elig    = (|halfSet) ? halfSet : ~src_empty;
`else
    logic unused_half;
    assign unused_half = ^src_half;
    assign elig        = ~src_empty;
`endif

    // Scan from rrLast+N down to rrLast+1. The last hit is the first
    // eligible channel after rrLast in round-robin order.
    always_comb begin
        int scan;
        pickFound = 1'b0;
        pickIdx   = '0;
        scan      = 0;
        for (int k = N; k >= 1; k--) begin
            scan = (int'(rrLast_q) + k) % N;
            if (elig[scan]) begin
                pickFound = 1'b1;
                pickIdx   = CW'(scan);
            end
        end
    end

    // The sink view is driven directly from the registered grant.
    // Flush suppresses valid, so no word can move in the abort cycle.
    always_comb begin
        out_valid = (state_q == BURST_ST) && !src_empty[grant_q] && !flush;
        out_data  = srcWord[grant_q];
        out_chan  = grant_q;
        out_last  = out_valid && (beatCnt_q == BCW'(BURST - 1));
        move      = out_valid && out_ready;
        src_read  = '0;
        if (move) begin
            src_read[grant_q] = 1'b1;
        end
    end

    assign busy  = (state_q == BURST_ST);
    assign abort = abort_q;

    // Next-state logic.
    // Flush overrides everything.
    // A burst ends on its full-length last beat, or on the first cycle
    // its source is found empty.
    always_comb begin
        state_d   = state_q;
        beatCnt_d = beatCnt_q;
        grant_d   = grant_q;
        rrLast_d  = rrLast_q;
        abort_d   = 1'b0;
        if (flush) begin
            state_d   = IDLE;
            beatCnt_d = '0;
            grant_d   = '0;
            rrLast_d  = CW'(N - 1);
        end else begin
            case (state_q)
                IDLE: begin
                    if (pickFound) begin
                        grant_d   = pickIdx;
                        state_d   = BURST_ST;
                        beatCnt_d = '0;
                    end
                end
                BURST_ST: begin
                    if (src_empty[grant_q]) begin
                        state_d  = IDLE;
                        rrLast_d = grant_q;
                        abort_d  = 1'b1;
                    end else if (move) begin
                        beatCnt_d = beatCnt_q + 1'b1;
                        if (out_last) begin
                            state_d  = IDLE;
                            rrLast_d = grant_q;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State registers.
    // After reset, rrLast is N-1 so that channel 0 is served first.
    always_ff @(posedge clk or negedge rest) begin
        if (!rest) begin
            state_q   <= IDLE;
            beatCnt_q <= '0;
            grant_q   <= '0;
            rrLast_q  <= CW'(N - 1);
            abort_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            beatCnt_q <= beatCnt_d;
            grant_q   <= grant_d;
            rrLast_q  <= rrLast_d;
            abort_q   <= abort_d;
        end
    end

endmodule

// File: tb/tb_fifo_rr_burst_arbiter.sv
// ---------------------------------------------------------------------------
// tb_fifo_rr_burst_arbiter
//
// Self-checking bench for fifo_rr_burst_arbiter. It uses N=4, WIDTH=32 and
// BURST=8.
//
// The bench models the source FIFOs as arrays. When data is loaded, a
// burst-level reference model predicts the complete word stream and the
// abort count. A separate monitor process compares each word that moves.
// ---------------------------------------------------------------------------
module tb_fifo_rr_burst_arbiter;

    localparam int N     = 4;
    localparam int WIDTH = 32;
    localparam int BURST = 8;
    localparam int CW    = 2;
    localparam int HALF  = 8;
    localparam int DEPTH = 256;

    logic               clk;
    logic               rest;
    logic               flush;
    logic [N-1:0]       src_empty;
    logic [N-1:0]       src_half;
    logic [N*WIDTH-1:0] src_data;
    logic [N-1:0]       src_read;
    logic               out_valid;
    logic               out_ready;
    logic [WIDTH-1:0]   out_data;
    logic [CW-1:0]      out_chan;
    logic               out_last;
    logic               abort;
    logic               busy;

    typedef struct {
        int               chan;
        logic [WIDTH-1:0] data;
        logic             last;
    } exp_t;

    exp_t             sb[$];
    logic [WIDTH-1:0] mem [N][DEPTH];
    int               head [N] = '{default: 0};
    int               tail [N] = '{default: 0};
    logic [N-1:0]     popMask = '0;
    int               readyMode = 0;
    logic             flushReq = 1'b0;
    int               modelRr = N - 1;
    int               expAborts = 0;
    int               abortSeen = 0;
    int               moves = 0;
    int               vectors = 0;
    int               miscompares = 0;

    fifo_rr_burst_arbiter #(.N(N), .WIDTH(WIDTH), .BURST(BURST)) dut (
        .clk(clk), .rest(rest), .flush(flush),
        .src_empty(src_empty), .src_half(src_half), .src_data(src_data),
        .src_read(src_read), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_chan(out_chan), .out_last(out_last),
        .abort(abort), .busy(busy)
    );

    // 10-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Watchdog so the run can never hang.
    initial begin
        #600000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Source FIFO model.
    // Just after each rising edge, it applies the reads seen in the previous
    // cycle and re-drives flags, data, ready and flush.
    initial begin
        int phase;
        phase     = 0;
        src_empty = '1;
        src_half  = '0;
        src_data  = '0;
        out_ready = 1'b0;
        flush     = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++) begin
                if (popMask[i]) head[i]++;
                src_empty[i] = (head[i] == tail[i]);
                src_half[i]  = ((tail[i] - head[i]) >= HALF);
                src_data[i*WIDTH +: WIDTH] = src_empty[i] ? '0 : mem[i][head[i]];
            end
            case (readyMode)
                0:       out_ready = 1'b1;
                1:       out_ready = (phase % 3 == 0);
                default: out_ready = ($urandom_range(0, 3) != 0);
            endcase
            phase++;
            flush = flushReq;
        end
    end

    // Monitor.
    // Every word that moves must match the head of the scoreboard.
    // Read strobes must match the moves.
    // Data and channel must hold steady through a stall.
    initial begin
        logic             prevStall;
        logic [WIDTH-1:0] prevData;
        logic [CW-1:0]    prevChan;
        logic [N-1:0]     expRead;
        exp_t             e;
        prevStall = 1'b0;
        prevData  = '0;
        prevChan  = '0;
        forever begin
            @(negedge clk);
            expRead = '0;
            if (out_valid) begin
                checkOutput("busy while valid", busy, 1);
                if (prevStall) begin
                    checkOutput("stall data hold", out_data, prevData);
                    checkOutput("stall chan hold", out_chan, prevChan);
                end
            end
            if (out_valid && out_ready) begin
                moves++;
                if (sb.size() == 0) begin
                    checkOutput("unexpected word", 1, 0);
                end else begin
                    e = sb.pop_front();
                    checkOutput("word chan", out_chan, e.chan);
                    checkOutput("word data", out_data, e.data);
                    checkOutput("word last", out_last, e.last);
                    if (e.chan >= 0 && e.chan < N) expRead[e.chan] = 1'b1;
                end
            end
            checkOutput("src_read", src_read, expRead);
            if (abort) abortSeen++;
            prevStall = out_valid && !out_ready;
            prevData  = out_data;
            prevChan  = out_chan;
            popMask   = src_read;
        end
    end

    // Burst-level reference model.
    // Repeatedly pick the next non-empty channel after the last one served,
    // preferring half-full channels when that feature is built in.
    // Take min(BURST, fill) words from it.
    // A burst shorter than BURST ends with one abort.
    function automatic void modelRun();
        int  sz [N];
        int  hd [N];
        bit  cand [N];
        bit  anyHalf;
        int  pick;
        int  take;
        int  c;
        exp_t e;
        for (int i = 0; i < N; i++) begin
            hd[i] = head[i];
            sz[i] = tail[i] - head[i];
        end
        for (int guard = 0; guard < 1000; guard++) begin
            anyHalf = 1'b0;
            for (int i = 0; i < N; i++) cand[i] = (sz[i] > 0);
`ifdef FIFO_ARB_HALF_PRIO_EN
            for (int i = 0; i < N; i++) if (sz[i] >= HALF) anyHalf = 1'b1;
            if (anyHalf) for (int i = 0; i < N; i++) cand[i] = (sz[i] >= HALF);
`endif
            pick = -1;
            for (int k = 1; k <= N; k++) begin
                c = (modelRr + k) % N;
                if (pick < 0 && cand[c]) pick = c;
            end
            if (pick < 0) break;
            take = (sz[pick] < BURST) ? sz[pick] : BURST;
            for (int j = 0; j < take; j++) begin
                e.chan = pick;
                e.data = mem[pick][hd[pick] + j];
                e.last = (j == BURST - 1);
                sb.push_back(e);
            end
            if (take < BURST) expAborts++;
            hd[pick] += take;
            sz[pick] -= take;
            modelRr   = pick;
        end
    endfunction

    task automatic applyStimulus(input int ch, input int count);
        if (head[ch] == tail[ch]) begin
            head[ch] = 0;
            tail[ch] = 0;
        end
        for (int j = 0; j < count; j++) begin
            mem[ch][tail[ch]] = $urandom;
            tail[ch]++;
        end
    endtask

    task automatic drainAndCheck(input string name);
        int cyc;
        cyc = 0;
        while (sb.size() != 0 && cyc < 3000) begin
            @(negedge clk);
            cyc++;
        end
        checkOutput({name, " words left"}, sb.size(), 0);
        repeat (4) @(negedge clk);
        #2;
        checkOutput({name, " aborts"}, abortSeen, expAborts);
        checkOutput({name, " idle"}, busy, 0);
        abortSeen = 0;
        expAborts = 0;
    endtask

    task automatic idleFlush();
        @(negedge clk); #2;
        flushReq = 1'b1;
        @(negedge clk); #2;
        flushReq = 1'b0;
        modelRr  = N - 1;
        @(negedge clk); #2;
        abortSeen = 0;
    endtask

    initial begin
        int cyc;
        int base;
        logic [CW-1:0] expFirst;
        rest = 1'b0;

        // Reset state
        repeat (3) begin
            @(negedge clk);
            checkOutput("reset out_valid", out_valid, 0);
            checkOutput("reset busy", busy, 0);
            checkOutput("reset abort", abort, 0);
            checkOutput("reset src_read", src_read, 0);
        end
        #2 rest = 1'b1;

        // All sources empty for 20 cycles
        repeat (20) begin
            @(negedge clk);
            checkOutput("empty out_valid", out_valid, 0);
            checkOutput("empty busy", busy, 0);
        end
        #2;

        // ch1 holds 20 words, sink always ready
        readyMode = 0;
        applyStimulus(1, 20);
        modelRun();
        drainAndCheck("ch1 burst");

        // All four channels hold 16 words
        idleFlush();
        for (int i = 0; i < N; i++) applyStimulus(i, 16);
        modelRun();
        drainAndCheck("four channels");

        // ch2 with ready pattern 1,0,0
        readyMode = 1;
        applyStimulus(2, 20);
        modelRun();
        drainAndCheck("ch2 stalled");

        // Flush on the third beat of a ch0 burst
        readyMode = 0;
        idleFlush();
        base = moves;
        applyStimulus(0, 16);
        modelRun();
        cyc = 0;
        while (moves < base + 2 && cyc < 200) begin
            @(negedge clk); #2;
            cyc++;
        end
        checkOutput("flush setup moves", moves - base, 2);
        flushReq = 1'b1;
        @(negedge clk); #2;
        flushReq = 1'b0;
        sb.delete();
        expAborts = 0;
        abortSeen = 0;
        modelRr   = N - 1;
        modelRun();
        @(negedge clk);
        checkOutput("after flush busy", busy, 0);
        checkOutput("after flush src_read", src_read, 0);
        #2;
        drainAndCheck("after flush");

        // Half-flag priority: ch0 light, ch3 half full, rrLast = 3
        idleFlush();
        applyStimulus(0, 2);
        applyStimulus(3, 12);
        modelRun();
`ifdef FIFO_ARB_HALF_PRIO_EN
        expFirst = 2'd3;
`else
        expFirst = 2'd0;
`endif
        cyc = 0;
        while (!busy && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        checkOutput("first grant", out_chan, expFirst);
        #2;
        drainAndCheck("half prio");

        // Random fills with random sink backpressure
        readyMode = 2;
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < N; i++) applyStimulus(i, $urandom_range(0, 20));
            modelRun();
            drainAndCheck("random round");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
